// File: rtl/hazard_ctrl_mc_if.sv
`default_nettype none
// ============================================================================
// hazard_ctrl_mc_if : datapath <-> hazard controller signal bundle
// Rev 1.0
// ============================================================================
interface hazard_ctrl_mc_if #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
);
    logic [REG_AW-1:0] rs1_d;
    logic [REG_AW-1:0] rs2_d;
    logic [REG_AW-1:0] rs1_e;
    logic [REG_AW-1:0] rs2_e;
    logic [REG_AW-1:0] rd_e;
    logic [REG_AW-1:0] rd_m;
    logic [REG_AW-1:0] rd_w;
    logic [1:0]        wb_src_e;
    logic              regwrite_m;
    logic              regwrite_w;
    logic              mem_req_m;
    logic              pc_sel_e;
    logic              mdu_op_e;
    logic              mdu_done;

    logic              stall_f;
    logic              stall_d;
    logic              stall_e;
    logic              stall_m;
    logic              flush_d;
    logic              flush_e;
    logic              flush_m;
    logic              flush_w;
    logic              mdu_go;
    logic [1:0]        forward_a;
    logic [1:0]        forward_b;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;

    // Datapath side
    modport master (
        output rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w, wb_src_e,
               regwrite_m, regwrite_w, mem_req_m, pc_sel_e, mdu_op_e, mdu_done,
        input  stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_m,
               flush_w, mdu_go, forward_a, forward_b, stall_cnt, flush_cnt
    );

    // Hazard controller side
    modport slave (
        input  rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w, wb_src_e,
               regwrite_m, regwrite_w, mem_req_m, pc_sel_e, mdu_op_e, mdu_done,
        output stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_m,
               flush_w, mdu_go, forward_a, forward_b, stall_cnt, flush_cnt
    );
endinterface
`default_nettype wire

// File: rtl/hazard_ctrl_mc.sv
`default_nettype none
// ============================================================================
// hazard_ctrl_mc : 5-stage hazard controller with memory wait states,
//                  MDU busy handshake and saturating perf counters
// Rev 1.0
// ============================================================================
module hazard_ctrl_mc #(
    parameter int REG_AW   = 5,
    parameter int MEM_WAIT = 0,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    hazard_ctrl_mc_if.slave  hz
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_MDU_BUSY = 2'd2
    } state_t;

    localparam int                c_wait_w      = (MEM_WAIT > 2) ? $clog2(MEM_WAIT) : 1;
    localparam int                c_wait_init_i = (MEM_WAIT >= 2) ? (MEM_WAIT - 2) : 0;
    localparam logic [c_wait_w-1:0] c_wait_init = c_wait_init_i[c_wait_w-1:0];

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_wait_w-1:0] r_cnt;
    logic [c_wait_w-1:0] w_cnt_nxt;
    logic                r_mem_ack;
    logic                w_mem_ack_nxt;
    logic [CNT_W-1:0]    r_stall_cnt;
    logic [CNT_W-1:0]    r_flush_cnt;
    logic [CNT_W-1:0]    w_stall_cnt_nxt;
    logic [CNT_W-1:0]    w_flush_cnt_nxt;

    logic w_mem_stall;
    logic w_mdu_go;
    logic w_mdu_stall;
    logic w_hold_e;
    logic w_load_use;
    logic w_branch;
    logic w_ack_set;
    logic w_stall_f;
    logic w_flush_d;
    logic [1:0] w_fwd_a;
    logic [1:0] w_fwd_b;

    // Operand forwarding: M result beats W result, x0 never forwarded
    always_comb begin
        w_fwd_a = 2'b00;
        w_fwd_b = 2'b00;
        if (rst_n) begin
            if (hz.rs1_e != '0 && hz.regwrite_m && hz.rs1_e == hz.rd_m)
                w_fwd_a = 2'b10;
            else if (hz.rs1_e != '0 && hz.regwrite_w && hz.rs1_e == hz.rd_w)
                w_fwd_a = 2'b01;
            if (hz.rs2_e != '0 && hz.regwrite_m && hz.rs2_e == hz.rd_m)
                w_fwd_b = 2'b10;
            else if (hz.rs2_e != '0 && hz.regwrite_w && hz.rs2_e == hz.rd_w)
                w_fwd_b = 2'b01;
        end
    end

    always_comb begin
        w_mem_stall = 1'b0;
        if (MEM_WAIT != 0)
            w_mem_stall = (r_state == ST_MEM_WAIT) ||
                          (r_state == ST_IDLE && hz.mem_req_m && !r_mem_ack);
        w_mdu_go    = (r_state == ST_IDLE) && !w_mem_stall && hz.mdu_op_e;
        w_mdu_stall = w_mdu_go || (r_state == ST_MDU_BUSY && !hz.mdu_done);
        w_hold_e    = w_mem_stall || w_mdu_stall;
        w_load_use  = (r_state == ST_IDLE) && !w_hold_e && (hz.wb_src_e == 2'b01) &&
                      (hz.rd_e != '0) && (hz.rd_e == hz.rs1_d || hz.rd_e == hz.rs2_d);
        // A held E stage defers the redirect until the release cycle
        w_branch    = hz.pc_sel_e && !w_hold_e;
        w_stall_f   = rst_n && (w_hold_e || (w_load_use && !w_branch));
        w_flush_d   = rst_n && w_branch;

        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_ack_set   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_mem_stall) begin
                    if (MEM_WAIT == 1) begin
                        w_ack_set = 1'b1;
                    end else begin
                        w_state_nxt = ST_MEM_WAIT;
                        w_cnt_nxt   = c_wait_init;
                    end
                end else if (w_mdu_go) begin
                    w_state_nxt = ST_MDU_BUSY;
                end
            end
            ST_MEM_WAIT: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ST_IDLE;
                    w_ack_set   = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - c_wait_w'(1);
                end
            end
            ST_MDU_BUSY: begin
                if (hz.mdu_done)
                    w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        // The ack masks the still-present request for one cycle after the wait
        w_mem_ack_nxt = w_ack_set ? 1'b1 : (w_mem_stall ? r_mem_ack : 1'b0);

        w_stall_cnt_nxt = r_stall_cnt;
        w_flush_cnt_nxt = r_flush_cnt;
        if (w_stall_f && r_stall_cnt != '1)
            w_stall_cnt_nxt = r_stall_cnt + CNT_W'(1);
        if (w_flush_d && r_flush_cnt != '1)
            w_flush_cnt_nxt = r_flush_cnt + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_mem_ack   <= 1'b0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_mem_ack   <= w_mem_ack_nxt;
            r_stall_cnt <= w_stall_cnt_nxt;
            r_flush_cnt <= w_flush_cnt_nxt;
        end
    end

    assign hz.stall_f   = w_stall_f;
    assign hz.stall_d   = w_stall_f;
    assign hz.stall_e   = rst_n && w_hold_e;
    assign hz.stall_m   = rst_n && w_mem_stall;
    assign hz.flush_d   = w_flush_d;
    assign hz.flush_e   = rst_n && (w_branch || w_load_use);
    assign hz.flush_m   = rst_n && w_mdu_stall;
    assign hz.flush_w   = rst_n && w_mem_stall;
    assign hz.mdu_go    = rst_n && w_mdu_go;
    assign hz.forward_a = w_fwd_a;
    assign hz.forward_b = w_fwd_b;
    assign hz.stall_cnt = r_stall_cnt;
    assign hz.flush_cnt = r_flush_cnt;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl_mc.sv
`default_nettype none
// ============================================================================
// tb_hazard_ctrl_mc : scoreboard bench for hazard_ctrl_mc (MEM_WAIT 3 and 2)
// Rev 1.0
// ============================================================================
module tb_hazard_ctrl_mc;

    // {stall_f,stall_d,stall_e,stall_m,flush_d,flush_e,flush_m,flush_w,mdu_go}
    localparam logic [8:0] c_none = 9'b000000000;
    localparam logic [8:0] c_mems = 9'b111100010;
    localparam logic [8:0] c_mdug = 9'b111000101;
    localparam logic [8:0] c_mdub = 9'b111000100;
    localparam logic [8:0] c_lu   = 9'b110001000;
    localparam logic [8:0] c_br   = 9'b000011000;

    typedef struct {
        string      tag;
        logic [8:0] ctl;
        logic [3:0] fwd;
        logic [3:0] scnt;
        logic [3:0] fcnt;
        bit         chk_b;
        logic [8:0] ctl_b;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
    logic [1:0] wb_src_e;
    logic regwrite_m, regwrite_w, mem_req_m, pc_sel_e, mdu_op_e, mdu_done;

    int   n_checks = 0;
    int   n_errors = 0;
    int   run_s = 0;
    int   run_f = 0;
    exp_t sb[$];
    exp_t mon_e;

    hazard_ctrl_mc_if #(.REG_AW(5), .CNT_W(4))  ifa();
    hazard_ctrl_mc_if #(.REG_AW(5), .CNT_W(32)) ifb();

    hazard_ctrl_mc #(.REG_AW(5), .MEM_WAIT(3), .CNT_W(4)) u_dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (ifa)
    );

    hazard_ctrl_mc #(.REG_AW(5), .MEM_WAIT(2), .CNT_W(32)) u_dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (ifb)
    );

    assign ifa.rs1_d = rs1_d;           assign ifb.rs1_d = rs1_d;
    assign ifa.rs2_d = rs2_d;           assign ifb.rs2_d = rs2_d;
    assign ifa.rs1_e = rs1_e;           assign ifb.rs1_e = rs1_e;
    assign ifa.rs2_e = rs2_e;           assign ifb.rs2_e = rs2_e;
    assign ifa.rd_e = rd_e;             assign ifb.rd_e = rd_e;
    assign ifa.rd_m = rd_m;             assign ifb.rd_m = rd_m;
    assign ifa.rd_w = rd_w;             assign ifb.rd_w = rd_w;
    assign ifa.wb_src_e = wb_src_e;     assign ifb.wb_src_e = wb_src_e;
    assign ifa.regwrite_m = regwrite_m; assign ifb.regwrite_m = regwrite_m;
    assign ifa.regwrite_w = regwrite_w; assign ifb.regwrite_w = regwrite_w;
    assign ifa.mem_req_m = mem_req_m;   assign ifb.mem_req_m = mem_req_m;
    assign ifa.pc_sel_e = pc_sel_e;     assign ifb.pc_sel_e = pc_sel_e;
    assign ifa.mdu_op_e = mdu_op_e;     assign ifb.mdu_op_e = mdu_op_e;
    assign ifa.mdu_done = mdu_done;     assign ifb.mdu_done = mdu_done;

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        rs1_d = '0; rs2_d = '0; rs1_e = '0; rs2_e = '0;
        rd_e = '0; rd_m = '0; rd_w = '0; wb_src_e = '0;
        regwrite_m = 1'b0; regwrite_w = 1'b0; mem_req_m = 1'b0;
        pc_sel_e = 1'b0; mdu_op_e = 1'b0; mdu_done = 1'b0;
    endtask

    // Counters are registered: this cycle shows the stalls/flushes of earlier cycles
    task automatic push(input string tag, input logic [8:0] ctl, input logic [3:0] fwd,
                        input bit chk_b, input logic [8:0] ctl_b);
        exp_t e;
        e.tag = tag; e.ctl = ctl; e.fwd = fwd; e.chk_b = chk_b; e.ctl_b = ctl_b;
        e.scnt = 4'(run_s);
        e.fcnt = 4'(run_f);
        sb.push_back(e);
        if (!rst_n) begin
            run_s = 0;
            run_f = 0;
        end else begin
            if (ctl[8] && run_s != 15) run_s++;
            if (ctl[4] && run_f != 15) run_f++;
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            chk($sformatf("%s_ctl", mon_e.tag),
                {23'b0, ifa.stall_f, ifa.stall_d, ifa.stall_e, ifa.stall_m, ifa.flush_d,
                 ifa.flush_e, ifa.flush_m, ifa.flush_w, ifa.mdu_go}, {23'b0, mon_e.ctl});
            chk($sformatf("%s_fwd", mon_e.tag),
                {28'b0, ifa.forward_a, ifa.forward_b}, {28'b0, mon_e.fwd});
            chk($sformatf("%s_scnt", mon_e.tag), {28'b0, ifa.stall_cnt}, {28'b0, mon_e.scnt});
            chk($sformatf("%s_fcnt", mon_e.tag), {28'b0, ifa.flush_cnt}, {28'b0, mon_e.fcnt});
            if (mon_e.chk_b)
                chk($sformatf("%s_ctlB", mon_e.tag),
                    {23'b0, ifb.stall_f, ifb.stall_d, ifb.stall_e, ifb.stall_m, ifb.flush_d,
                     ifb.flush_e, ifb.flush_m, ifb.flush_w, ifb.mdu_go}, {23'b0, mon_e.ctl_b});
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        clear_in();

        tick(); rs1_e = 5; rd_m = 5; regwrite_m = 1'b1;
        push("reset", c_none, 4'b0000, 1'b1, c_none);

        // Memory request and MDU op together: A waits 3, B waits 2, then MDU starts
        tick(); rst_n = 1'b1; clear_in(); mem_req_m = 1'b1; mdu_op_e = 1'b1;
        push("coin1", c_mems, 4'b0000, 1'b1, c_mems);
        tick(); push("coin2", c_mems, 4'b0000, 1'b1, c_mems);
        tick(); push("coin3", c_mems, 4'b0000, 1'b1, c_mdug);
        tick(); mem_req_m = 1'b0;
        push("coin4", c_mdug, 4'b0000, 1'b1, c_mdub);
        tick(); push("mdu_busy", c_mdub, 4'b0000, 1'b1, c_mdub);
        for (int i = 0; i < 4; i++) begin
            tick(); pc_sel_e = (i >= 2);
            push("mdu_busy_br", c_mdub, 4'b0000, 1'b0, c_none);
        end
        tick(); mdu_done = 1'b1;
        push("mdu_done_br", c_br, 4'b0000, 1'b0, c_none);
        tick(); mdu_done = 1'b0; pc_sel_e = 1'b0; mdu_op_e = 1'b0;
        push("mdu_after", c_none, 4'b0000, 1'b0, c_none);

        tick(); rs1_e = 5; rd_m = 5; rd_w = 5; regwrite_m = 1'b1; regwrite_w = 1'b1;
        push("fwd_m", c_none, 4'b1000, 1'b0, c_none);
        tick(); rd_m = 0;
        push("fwd_w", c_none, 4'b0100, 1'b0, c_none);
        tick(); rs1_e = 0;
        push("fwd_x0", c_none, 4'b0000, 1'b0, c_none);
        tick(); rs1_e = 5; rs2_e = 9; rd_m = 9;
        push("fwd_ab", c_none, 4'b0110, 1'b0, c_none);
        tick(); regwrite_m = 1'b0;
        push("fwd_nowm", c_none, 4'b0100, 1'b0, c_none);

        tick(); clear_in(); wb_src_e = 2'b01; rd_e = 7; rs2_d = 7;
        push("lu", c_lu, 4'b0000, 1'b0, c_none);
        tick(); clear_in();
        push("lu_bubble", c_none, 4'b0000, 1'b0, c_none);
        tick(); wb_src_e = 2'b01; rd_e = 0;
        push("lu_x0", c_none, 4'b0000, 1'b0, c_none);
        tick(); clear_in(); wb_src_e = 2'b01; rd_e = 7; rs1_d = 7; pc_sel_e = 1'b1;
        push("lu_br", c_br, 4'b0000, 1'b0, c_none);
        tick(); clear_in(); pc_sel_e = 1'b1;
        push("br", c_br, 4'b0000, 1'b0, c_none);
        tick(); clear_in();
        push("idle", c_none, 4'b0000, 1'b0, c_none);

        tick(); mem_req_m = 1'b1;
        push("mw1", c_mems, 4'b0000, 1'b0, c_none);
        tick(); push("mw2", c_mems, 4'b0000, 1'b0, c_none);
        tick(); push("mw3", c_mems, 4'b0000, 1'b0, c_none);
        tick(); push("mw_rel", c_none, 4'b0000, 1'b0, c_none);
        tick(); push("mw_next1", c_mems, 4'b0000, 1'b0, c_none);
        tick(); rst_n = 1'b0;
        push("mw_rst", c_none, 4'b0000, 1'b0, c_none);
        tick(); rst_n = 1'b1; mem_req_m = 1'b0;
        push("mw_post_rst", c_none, 4'b0000, 1'b0, c_none);

        // Long MDU op drives the 4-bit stall counter into saturation
        tick(); mdu_op_e = 1'b1;
        push("sat_go", c_mdug, 4'b0000, 1'b0, c_none);
        for (int i = 0; i < 17; i++) begin
            tick(); push("sat_busy", c_mdub, 4'b0000, 1'b0, c_none);
        end
        tick(); mdu_done = 1'b1;
        push("sat_done", c_none, 4'b0000, 1'b0, c_none);
        tick(); mdu_done = 1'b0; mdu_op_e = 1'b0;
        push("sat_hold", c_none, 4'b0000, 1'b0, c_none);
        tick(); mdu_done = 1'b1;
        push("stray_done", c_none, 4'b0000, 1'b0, c_none);
        tick(); mdu_done = 1'b0;
        push("final", c_none, 4'b0000, 1'b0, c_none);

        @(negedge clk);
        #1;
        chk("sb_drain", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
